// File: rtl/inv_req_scheduler_pkg.sv
// Shared constants for the inverter request scheduler: default operand width
// and the legacy FSM state encodings.
package inv_req_scheduler_pkg;

    localparam int WORD_SIZE = 446;

    localparam logic [1:0] INVS_IDLE  = 2'd0;
    localparam logic [1:0] INVS_ISSUE = 2'd1;
    localparam logic [1:0] INVS_WAIT  = 2'd2;
    localparam logic [1:0] INVS_RESP  = 2'd3;

endpackage

// File: rtl/inv_req_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr with wrap-around, returned one-hot and as an index.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic w_found;
    int   w_idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        any      = |req;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found         = 1'b1;
                grant[w_idx]    = 1'b1;
                grant_id        = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/inv_req_scheduler.sv
// Shares one Montgomery inverter among NREQ requesters: round-robin accept,
// start/comp sequencing, tagged response; zero operands bypass the inverter.
module inv_req_scheduler
    import inv_req_scheduler_pkg::*;
#(
    parameter  int W    = WORD_SIZE,
    parameter  int NREQ = 4,
    parameter  int CW   = 12,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_zero,
    output logic [CW-1:0]     rsp_cycles,
    output logic              busy,
    output logic              inv_start,
    output logic [W-1:0]      inv_a,
    input  logic [W-1:0]      inv_c,
    input  logic              inv_comp
);

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_op;
    logic [W-1:0]    r_res;
    logic            r_zero;
    logic [CW-1:0]   r_cnt;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gid;
    logic            w_any;
    logic [W-1:0]    w_sel_op;
    logic [IDW-1:0]  w_next_ptr;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req      (req_valid),
        .ptr      (r_ptr),
        .grant    (w_grant),
        .grant_id (w_gid),
        .any      (w_any)
    );

    assign w_sel_op   = req_data[w_gid*W +: W];
    assign w_next_ptr = (r_id == IDW'(NREQ-1)) ? '0 : r_id + IDW'(1);

    // Accept is offered only in IDLE and never while reset is held.
    assign req_ready  = (rst_n && r_state == INVS_IDLE) ? w_grant : '0;
    assign rsp_valid  = (r_state == INVS_RESP);
    assign rsp_id     = r_id;
    assign rsp_data   = r_res;
    assign rsp_zero   = r_zero;
    assign rsp_cycles = r_cnt;
    assign busy       = (r_state != INVS_IDLE);
    assign inv_start  = (r_state == INVS_ISSUE);
    assign inv_a      = r_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INVS_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_op    <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                INVS_IDLE: begin
                    if (w_any) begin
                        r_id <= w_gid;
                        r_op <= w_sel_op;
                        if (w_sel_op == '0) begin
                            r_res   <= '0;
                            r_zero  <= 1'b1;
                            r_state <= INVS_RESP;
                        end else begin
                            r_zero  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= INVS_ISSUE;
                        end
                    end
                end
                INVS_ISSUE: r_state <= INVS_WAIT;
                INVS_WAIT: begin
                    r_cnt <= sat_inc(r_cnt);
                    if (inv_comp) begin
                        r_res   <= inv_c;
                        r_state <= INVS_RESP;
                    end
                end
                INVS_RESP: begin
                    if (rsp_ready) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= INVS_IDLE;
                    end
                end
                default: r_state <= INVS_IDLE;
            endcase
        end
    end

endmodule

// File: doc/inv_req_scheduler.md
Name: inv_req_scheduler

Overview:
Shares one MontgomeryInverter instance among NREQ requesters, such as pairing final-exponentiation and Fp2/Fp12 inversion units. The block takes one operand at a time through a round-robin grant. It then sequences the inverter's start/comp protocol and returns the result tagged with the requester ID. Zero operands have no inverse, so they are answered directly and never reach the inverter.

Parameters:
W, `WORD_SIZE, operand/result width in bits (446 for BLS12-446).
NREQ, 4, number of requesters (2..8).
IDW, $clog2(NREQ) (localparam), width of the requester ID.
CW, 12, width of the saturating latency counter.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester operand valid
req_data  input  NREQ*W  operands; requester i occupies bits [i*W +: W]
req_ready  output  NREQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high
rsp_valid  output  1  result valid
rsp_ready  input  1  result consumer ready
rsp_id  output  IDW  requester that owns the result
rsp_data  output  W  Mont(a^-1), or 0 when the operand was zero
rsp_zero  output  1  operand was zero; no inversion performed
rsp_cycles  output  CW  cycles spent in WAIT, saturating at 2^CW-1
busy  output  1  state != IDLE
inv_start  output  1  to inverter start
inv_a  output  W  to inverter a
inv_c  input  W  from inverter c
inv_comp  input  1  from inverter comp (one-cycle pulse)

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, and the registers for id, operand, result, zero flag and counter are all 0.
- Outputs in reset: req_ready=0, rsp_valid=0, inv_start=0, busy=0, rsp_*=0, inv_a=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching upward from rr_ptr with wrap-around.
  - req_ready[g]=1 for exactly this cycle (combinational from req_valid, asserted only in IDLE).
  - Latch id<=g and op<=req_data[g].
  - If that operand is all zeros: result<=0, zero<=1, go to RESP.
  - Otherwise: zero<=0, cnt<=0, go to ISSUE.
  - No requests: stay in IDLE, all req_ready=0.
- ISSUE: inv_start=1 for exactly this one cycle, inv_a=op. Go to WAIT.
- inv_a is driven from the op register and held stable from ISSUE until the next grant.
- WAIT:
  - inv_start=0; cnt increments each cycle, saturating.
  - On inv_comp=1: result<=inv_c, go to RESP.
  - There is no timeout; the block waits indefinitely.
- RESP:
  - rsp_valid=1 with rsp_id, rsp_data, rsp_zero and rsp_cycles all from registers, held stable while stalled.
  - On rsp_ready=1: rr_ptr <= (id+1) mod NREQ, go to IDLE.
  - A new grant cannot occur in the same cycle as the response handshake, so throughput is at most one operation per (latency+2) cycles.
- Latency: accept at cycle T. inv_start at T+1. If inv_comp arrives at T+1+k, rsp_valid rises at T+2+k. The zero path gives rsp_valid at T+1.
- Inverter spacing: inv_comp and the next inv_start are always at least 3 cycles apart (RESP, IDLE, ISSUE). This guarantees the inverter is back in its idle state and has cleared comp before the next start.
- inv_comp outside WAIT is ignored, and must be flagged by an assertion in the bench.
- req_valid dropping while not granted is tolerated. A requester's valid is only sampled in IDLE.
- rr_ptr advances only on a completed response, including zero responses. This gives fairness: with all requesters active, the grant order is 0,1,2,3,0,...
- Mid-operation reset: the block returns to IDLE immediately. The inverter shares rst_n, so both sides restart consistently, and no stale comp is accepted after reset.

Decomposition:
- Shared header parameter.vh holds `WORD_SIZE` plus the FSM state encodings, defined there as `INVS_IDLE=2'd0`, `INVS_ISSUE=2'd1`, `INVS_WAIT=2'd2` and `INVS_RESP=2'd3`.
- One sub-module, rr_pick: a combinational round-robin picker with parameter NREQ.
  - Inputs: req, ptr.
  - Outputs: grant (one-hot), grant_id, any.
- The FSM, registers and counter live in inv_req_scheduler.

Test Plan:
- Single request: req_valid=4'b0100, operand=Mont(3), mock inverter with k=20 → req_ready=4'b0100 for one cycle, one inv_start pulse, rsp_valid 22 cycles after accept, rsp_id=2, rsp_data=Mont(3^-1 mod p), rsp_cycles=20, rsp_zero=0.
- Zero operand: requester 1 sends 0 → rsp_valid at T+1, rsp_zero=1, rsp_data=0, rsp_id=1, no inv_start observed.
- Fairness: all four requesters held valid, rsp_ready=1 → grant order 0,1,2,3,0,1, with each requester receiving exactly its own result.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → response outputs stay constant, req_ready stays 0, no inv_start; accept resumes the cycle after rsp_ready=1.
- Reset in WAIT: deassert rst_n 5 cycles after inv_start → all outputs 0 asynchronously; after release, a new request completes normally with the correct rsp_id.
- Real MontgomeryInverter, back-to-back: requests a=Mont(1) then a=Mont(2) → results Mont(1) and Mont(2^-1); inv_start is never high within 3 cycles after inv_comp.
